// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the framebuffer RAM arbiter.
package fb_pkg;

  localparam int FB_RAM_WIDTH = 32;
  localparam int FB_N_BITS    = 480 * 360 * 24;

  // Registered grant: which requester owns the RAM port this cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_addr_counter.sv
// Wrapping address counter: clear has priority, wraps MAX -> 0 on increment.
module fb_addr_counter #(
  parameter int MAX = 1,
  parameter int AW  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] addr,
  output logic          at_max
);

  localparam logic [AW-1:0] MAX_A = AW'(MAX);

  logic [AW-1:0] addr_q, addr_d;

  assign at_max = (addr_q == MAX_A);
  assign addr   = addr_q;

  // Next address: clear beats increment so a restart always lands on 0.
  always_comb begin
    addr_d = addr_q;
    if (clr)      addr_d = '0;
    else if (inc) addr_d = at_max ? '0 : addr_q + 1'b1;
  end

  // Address register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_q <= '0;
    else      addr_q <= addr_d;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM shared between display reader (priority) and writer.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter  int RAM_WIDTH    = FB_RAM_WIDTH,
  parameter  int N_BITS       = FB_N_BITS,
  localparam int RAM_DEPTH    = N_BITS / RAM_WIDTH,
  localparam int MAX_ADDRESS  = RAM_DEPTH - 1,
  localparam int ADDRESS_BITS = $clog2(RAM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    visible,
  input  logic                    rd_req,
  output logic                    rd_valid,
  output logic [RAM_WIDTH-1:0]    rd_data,
  input  logic                    wr_valid,
  input  logic [RAM_WIDTH-1:0]    wr_data,
  output logic                    wr_ready,
  output logic                    wr_frame_done,
  output logic [ADDRESS_BITS-1:0] ram_addr,
  output logic                    ram_we,
  output logic [RAM_WIDTH-1:0]    ram_wdata,
  input  logic [RAM_WIDTH-1:0]    ram_rdata
);

  fb_state_e               state_q, state_d;
  logic [ADDRESS_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [ADDRESS_BITS-1:0] rd_addr, wr_addr;
  logic [RAM_WIDTH-1:0]    wr_reg_q, wr_reg_d;
  logic                    rd_valid_q;
  logic                    wr_last_q, wr_last_d;
  logic                    wr_frame_done_q;
  logic                    rd_hit;
  logic                    wr_at_max;
  logic                    rd_at_max_unused;

  // Display reads only count during the active area and always win the port.
  assign rd_hit   = visible && rd_req;
  assign wr_ready = wr_valid && !rd_hit;

  // Grant selection and the RAM command it launches next cycle.
  always_comb begin
    state_d    = IDLE;
    ram_addr_d = ram_addr_q;
    wr_reg_d   = wr_reg_q;
    wr_last_d  = 1'b0;
    if (rd_hit) begin
      state_d    = READ;
      ram_addr_d = rd_addr;
    end else if (wr_ready) begin
      state_d    = WRITE;
      ram_addr_d = wr_addr;
      wr_reg_d   = wr_data;
      wr_last_d  = wr_at_max;
    end
  end

  // Grant/state register plus the read-return and frame-done pipelines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      ram_addr_q      <= '0;
      wr_reg_q        <= '0;
      rd_valid_q      <= 1'b0;
      wr_last_q       <= 1'b0;
      wr_frame_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ram_addr_q      <= ram_addr_d;
      wr_reg_q        <= wr_reg_d;
      rd_valid_q      <= (state_q == READ);
      wr_last_q       <= wr_last_d;
      wr_frame_done_q <= wr_last_q;
    end
  end

  // Display read pointer; frame_start restarts it, overriding a same-cycle increment.
  fb_addr_counter #(.MAX(MAX_ADDRESS), .AW(ADDRESS_BITS)) u_rd_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (frame_start),
    .inc    (state_d == READ),
    .addr   (rd_addr),
    .at_max (rd_at_max_unused)
  );

  // Writer pointer; runs freely across frames.
  fb_addr_counter #(.MAX(MAX_ADDRESS), .AW(ADDRESS_BITS)) u_wr_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .inc    (state_d == WRITE),
    .addr   (wr_addr),
    .at_max (wr_at_max)
  );

  assign ram_addr      = ram_addr_q;
  assign ram_we        = (state_q == WRITE);
  assign ram_wdata     = wr_reg_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_valid_q ? ram_rdata : '0;
  assign wr_frame_done = wr_frame_done_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed table, corner sequences, random traffic vs model.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int W     = 32;
  localparam int NB    = 32 * 128;
  localparam int DEPTH = NB / W;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst, frame_start, visible, rd_req, wr_valid;
  logic [W-1:0]  wr_data;
  logic          rd_valid, wr_ready, wr_frame_done, ram_we;
  logic [W-1:0]  rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  int vectors, miscompares;

  always #5 clk = ~clk;

  fb_arbiter #(.RAM_WIDTH(W), .N_BITS(NB)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .visible(visible),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .wr_frame_done(wr_frame_done), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [W-1:0] init_word(int i);
    return 32'hA5A5_0001 + W'(i);
  endfunction

  // RAM behaviour: 1-cycle read latency, read-before-write, known power-up contents.
  logic [W-1:0] mem [DEPTH];
  bit           written [DEPTH];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_word(int'(ram_addr));
  end

  // Reference model: pointers, memory image and what each grant should produce.
  logic [W-1:0] mmem [DEPTH];
  int           m_rd_ptr, m_wr_ptr, e_addr;
  logic         e_we, e_rv, e_done, g_rd, g_last;
  logic [W-1:0] e_wdata, e_rdata, g_rdata;

  task automatic m_reset();
    m_rd_ptr = 0; m_wr_ptr = 0; e_addr = 0;
    e_we = 0; e_rv = 0; e_done = 0; g_rd = 0; g_last = 0;
    e_wdata = '0; e_rdata = '0; g_rdata = '0;
  endtask

  task automatic m_step();
    e_rv    = g_rd;
    e_rdata = g_rd ? g_rdata : '0;
    e_done  = g_last;
    g_rd = 0; g_last = 0;
    if (visible && rd_req) begin
      e_addr = m_rd_ptr; e_we = 0; g_rd = 1; g_rdata = mmem[m_rd_ptr];
      m_rd_ptr = (m_rd_ptr + 1) % DEPTH;
    end else if (wr_valid) begin
      e_addr = m_wr_ptr; e_we = 1; e_wdata = wr_data; mmem[m_wr_ptr] = wr_data;
      g_last = (m_wr_ptr == DEPTH - 1);
      m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
    end else begin
      e_we = 0;
    end
    if (frame_start) m_rd_ptr = 0;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_wr_ready"}, W'(wr_ready), W'(wr_valid && !(visible && rd_req)));
    chk({tag, "_ram_addr"}, W'(ram_addr), W'(e_addr));
    chk({tag, "_ram_we"}, W'(ram_we), W'(e_we));
    chk({tag, "_ram_wdata"}, ram_wdata, e_wdata);
    chk({tag, "_rd_valid"}, W'(rd_valid), W'(e_rv));
    chk({tag, "_rd_data"}, rd_data, e_rdata);
    chk({tag, "_frame_done"}, W'(wr_frame_done), W'(e_done));
  endtask

  // Inputs are set at posedge+1; pre() lets combinational outputs settle.
  task automatic pre();
    #1;
    if (!rst) m_reset();
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rst) m_step();
  endtask

  task automatic idle_inputs();
    frame_start = 0; visible = 0; rd_req = 0; wr_valid = 0; wr_data = '0;
  endtask

  task automatic reset_cycle();
    rst = 0; idle_inputs();
    pre(); tick();
    rst = 1;
  endtask

  typedef struct {
    logic fs, vis, rr, wv; logic [W-1:0] wd;
    logic e_wrdy; int e_addr; logic e_we; logic [W-1:0] e_wdata;
    logic e_rv; logic [W-1:0] e_rdata; logic e_done;
  } vec_t;

  vec_t tbl [9];
  int   pulses, pulse_at, blank_ptr;
  logic hold;

  initial begin
    vectors = 0; miscompares = 0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = init_word(i);
    m_reset();
    rst = 0; idle_inputs();
    @(posedge clk); #1;

    // Reset held with random inputs: everything registered stays zero.
    for (int i = 0; i < 4; i++) begin
      rst = 0; frame_start = 1'($urandom); visible = 1'($urandom);
      rd_req = 1'($urandom); wr_valid = 1'($urandom); wr_data = $urandom;
      pre();
      chk("rst_ram_addr", W'(ram_addr), '0);
      chk("rst_ram_we", W'(ram_we), '0);
      chk("rst_ram_wdata", ram_wdata, '0);
      chk("rst_rd_valid", W'(rd_valid), '0);
      chk("rst_rd_data", rd_data, '0);
      chk("rst_frame_done", W'(wr_frame_done), '0);
      chk("rst_state", W'(dut.state_q), W'(IDLE));
      chk("rst_wr_ready", W'(wr_ready), W'(wr_valid && !(visible && rd_req)));
      tick();
    end

    // Read latency, restart, read/write conflict then write once reads stop.
    tbl[0] = '{0, 1, 1, 0, '0,           0, 0, 0, '0,           0, '0,           0};
    tbl[1] = '{0, 0, 0, 0, '0,           0, 0, 0, '0,           0, '0,           0};
    tbl[2] = '{1, 0, 0, 0, '0,           0, 0, 0, '0,           1, 32'hA5A5_0001, 0};
    tbl[3] = '{0, 1, 1, 1, 32'hDEAD_0001, 0, 0, 0, '0,           0, '0,           0};
    tbl[4] = '{0, 1, 1, 1, 32'hDEAD_0001, 0, 0, 0, '0,           0, '0,           0};
    tbl[5] = '{0, 1, 1, 1, 32'hDEAD_0001, 0, 1, 0, '0,           1, 32'hA5A5_0001, 0};
    tbl[6] = '{0, 1, 0, 1, 32'hDEAD_0001, 1, 2, 0, '0,           1, 32'hA5A5_0002, 0};
    tbl[7] = '{0, 0, 0, 0, '0,           0, 0, 1, 32'hDEAD_0001, 1, 32'hA5A5_0003, 0};
    tbl[8] = '{0, 0, 0, 0, '0,           0, 0, 0, 32'hDEAD_0001, 0, '0,           0};
    rst = 1;
    for (int i = 0; i < 9; i++) begin
      frame_start = tbl[i].fs; visible = tbl[i].vis; rd_req = tbl[i].rr;
      wr_valid = tbl[i].wv; wr_data = tbl[i].wd;
      pre();
      chk($sformatf("tbl%0d_wr_ready", i), W'(wr_ready), W'(tbl[i].e_wrdy));
      chk($sformatf("tbl%0d_ram_addr", i), W'(ram_addr), W'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_ram_we", i), W'(ram_we), W'(tbl[i].e_we));
      chk($sformatf("tbl%0d_ram_wdata", i), ram_wdata, tbl[i].e_wdata);
      chk($sformatf("tbl%0d_rd_valid", i), W'(rd_valid), W'(tbl[i].e_rv));
      chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].e_rdata);
      chk($sformatf("tbl%0d_frame_done", i), W'(wr_frame_done), W'(tbl[i].e_done));
      tick();
    end

    // Back-to-back writes across the whole RAM: one done pulse, then address 0 again.
    reset_cycle();
    pulses = 0; pulse_at = -1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      wr_valid = (i < DEPTH + 2); wr_data = $urandom;
      pre();
      chk_model("wrap");
      if (wr_frame_done) begin
        pulses++; pulse_at = i;
        chk("wrap_next_addr", W'(ram_addr), '0);
        chk("wrap_next_we", W'(ram_we), 32'd1);
      end
      tick();
    end
    chk("wrap_pulses", W'(pulses), 32'd1);
    chk("wrap_pulse_cycle", W'(pulse_at), W'(DEPTH + 1));

    // frame_start mid-frame at rd_addr 100, together with a read request.
    reset_cycle();
    idle_inputs(); visible = 1; rd_req = 1;
    for (int i = 0; i < 100; i++) begin
      pre(); chk_model("fs_fill"); tick();
    end
    frame_start = 1;
    pre(); chk_model("fs_pulse"); tick();
    frame_start = 0;
    pre(); chk("fs_same_cycle_addr", W'(ram_addr), 32'd100); chk_model("fs_n1"); tick();
    pre();
    chk("fs_restart_addr", W'(ram_addr), '0);
    chk("fs_inflight_rv", W'(rd_valid), 32'd1);
    chk("fs_inflight_data", rd_data, mmem[100]);
    chk_model("fs_n2");
    tick();

    // Blanking: rd_req ignored, no returns once the pipe drains, pointer held.
    visible = 0; rd_req = 1;
    blank_ptr = m_rd_ptr;
    for (int i = 0; i < 6; i++) begin
      pre();
      chk_model("blank");
      if (i >= 2) begin
        chk("blank_rd_valid", W'(rd_valid), '0);
        chk("blank_rd_data", rd_data, '0);
      end
      tick();
    end
    visible = 1;
    pre(); chk_model("blank_resume"); tick();
    rd_req = 0;
    pre(); chk("blank_held_addr", W'(ram_addr), W'(blank_ptr)); chk_model("blank_after"); tick();

    // Random traffic with a writer that holds its word while blocked.
    reset_cycle();
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      hold = rst && wr_valid && visible && rd_req;
      rst = ($urandom_range(0, 99) != 0);
      frame_start = ($urandom_range(0, 29) == 0);
      visible = ($urandom_range(0, 3) != 0);
      rd_req = 1'($urandom);
      if (!hold) begin
        wr_valid = 1'($urandom); wr_data = $urandom;
      end
      pre(); chk_model("rand"); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
